speicher_antwort: RTL and testbench

//  Memory responder for the Steuerung request signals. Serves instruction fetches
//  (LoadBefehlSignal), data loads (LoadDatenSignal) and data stores (StoreDatenSignal)

---
 rtl/speicher_antwort.sv | 197 +++++++++++++++++++
 tb/tb_speicher_antwort.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_antwort.sv
// Memory responder: serves fetch, load and store requests from an internal word RAM
// after a fixed number of wait states. Optional misalignment trap via ALIGN_CHECK_EN.
module speicher_antwort #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAITSTATES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic                  LoadDatenSignal,
    input  logic                  StoreDatenSignal,
    input  logic [ADDR_WIDTH-1:0] Befehlsadresse,
    input  logic [ADDR_WIDTH-1:0] Datenadresse,
    input  logic [DATA_WIDTH-1:0] Schreibdaten,
    output logic [DATA_WIDTH-1:0] Befehl,
    output logic [DATA_WIDTH-1:0] Lesedaten,
    output logic                  BefehlGeladen,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic                  Fehler
);

    typedef enum logic [1:0] {
        IDLE,
        WARTEN,
        ANTWORT,
        FREIGABE
    } Zustand;

    typedef enum logic [1:0] {
        ART_BEFEHL,
        ART_LADEN,
        ART_SPEICHERN
    } Art;

    localparam logic [3:0] WARTEZYKLEN = 4'(WAITSTATES);

    Zustand                  zustand;
    Zustand                  naechsterZustand;
    Art                      art;
    Art                      neueArt;
    logic                    annehmen;
    logic                    antworten;
    logic                    anfrageAktiv;
    logic                    gesperrt;
    logic [ADDR_WIDTH-1:0]   neueAdresse;
    logic [3:0]              zaehler;
    logic [DEPTH_LOG2-1:0]   wortIndex;
    logic [DATA_WIDTH-1:0]   datenLatch;

    logic [DATA_WIDTH-1:0]   speicher [0:(1<<DEPTH_LOG2)-1];

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand <= IDLE;
        end else begin
            zustand <= naechsterZustand;
        end
    end

    // The request currently being served; FREIGABE waits for this one to drop
    always_comb begin
        anfrageAktiv = 1'b0;
        case (art)
            ART_BEFEHL:    anfrageAktiv = LoadBefehlSignal;
            ART_LADEN:     anfrageAktiv = LoadDatenSignal;
            ART_SPEICHERN: anfrageAktiv = StoreDatenSignal;
            default:       anfrageAktiv = 1'b0;
        endcase
    end

    // Next-state logic with request arbitration: store beats load beats fetch
    always_comb begin
        naechsterZustand = zustand;
        annehmen         = 1'b0;
        antworten        = 1'b0;
        neueArt          = art;
        neueAdresse      = Befehlsadresse;
        case (zustand)
            IDLE: begin
                if (StoreDatenSignal) begin
                    annehmen    = 1'b1;
                    neueArt     = ART_SPEICHERN;
                    neueAdresse = Datenadresse;
                end else if (LoadDatenSignal) begin
                    annehmen    = 1'b1;
                    neueArt     = ART_LADEN;
                    neueAdresse = Datenadresse;
                end else if (LoadBefehlSignal) begin
                    annehmen    = 1'b1;
                    neueArt     = ART_BEFEHL;
                    neueAdresse = Befehlsadresse;
                end
                if (annehmen) begin
                    naechsterZustand = WARTEN;
                end
            end
            WARTEN: begin
                if (zaehler == 4'd0) begin
                    naechsterZustand = ANTWORT;
                end
            end
            ANTWORT: begin
                antworten        = 1'b1;
                naechsterZustand = FREIGABE;
            end
            FREIGABE: begin
                if (!anfrageAktiv) begin
                    naechsterZustand = IDLE;
                end
            end
            default: naechsterZustand = IDLE;
        endcase
    end

    // Request latch, wait counter, read data and done pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            art              <= ART_BEFEHL;
            wortIndex        <= '0;
            datenLatch       <= '0;
            zaehler          <= 4'd0;
            Befehl           <= '0;
            Lesedaten        <= '0;
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
        end else begin
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            if (annehmen) begin
                art        <= neueArt;
                wortIndex  <= neueAdresse[DEPTH_LOG2+1:2];
                datenLatch <= Schreibdaten;
                zaehler    <= WARTEZYKLEN;
            end else if (zustand == WARTEN && zaehler != 4'd0) begin
                zaehler <= zaehler - 4'd1;
            end
            if (antworten) begin
                case (art)
                    ART_BEFEHL: begin
                        BefehlGeladen <= 1'b1;
                        if (!gesperrt) begin
                            Befehl <= speicher[wortIndex];
                        end
                    end
                    ART_LADEN: begin
                        DatenGeladen <= 1'b1;
                        if (!gesperrt) begin
                            Lesedaten <= speicher[wortIndex];
                        end
                    end
                    ART_SPEICHERN: begin
                        DatenGespeichert <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM write; contents survive reset, and a reset edge suppresses a pending commit
    always_ff @(posedge Clock) begin
        if (!Reset && antworten && art == ART_SPEICHERN && !gesperrt) begin
            speicher[wortIndex] <= datenLatch;
        end
    end

`ifdef ALIGN_CHECK_EN
    logic fehlAusgerichtet;
    logic fehlerReg;

    // Misalignment is judged on the address captured at acceptance
    always_ff @(posedge Clock) begin
        if (Reset) begin
            fehlAusgerichtet <= 1'b0;
            fehlerReg        <= 1'b0;
        end else begin
            if (annehmen) begin
                fehlAusgerichtet <= |neueAdresse[1:0];
            end
            fehlerReg <= antworten && fehlAusgerichtet;
        end
    end

    assign gesperrt = fehlAusgerichtet;
    assign Fehler   = fehlerReg;
`else
    assign gesperrt = 1'b0;
    assign Fehler   = 1'b0;
`endif

endmodule

// File: tb/tb_speicher_antwort.sv
// Self-checking bench for speicher_antwort: transaction model with scheduled done pulses
// plus literal checks for the key scenarios. Honours ALIGN_CHECK_EN when defined.
module tb_speicher_antwort;

    localparam int WS        = 2;
    localparam int RAM_WORTE = 1024;
    localparam int ART_BEFEHL    = 0;
    localparam int ART_LADEN     = 1;
    localparam int ART_SPEICHERN = 2;
`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        int          zyklus;
        int          art;
        logic [31:0] adr;
        logic [31:0] wert;
    } ErwartungT;

    logic        Clock;
    logic        Reset;
    logic        LoadBefehlSignal;
    logic        LoadDatenSignal;
    logic        StoreDatenSignal;
    logic [31:0] Befehlsadresse;
    logic [31:0] Datenadresse;
    logic [31:0] Schreibdaten;
    logic [31:0] Befehl;
    logic [31:0] Lesedaten;
    logic        BefehlGeladen;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic        Fehler;

    int          zyklus = 0;
    int          checks = 0;
    int          errors = 0;
    bit          modelAktiv = 1'b0;
    ErwartungT   erwartet[$];
    logic [31:0] ramModel [0:RAM_WORTE-1];
    logic [31:0] expBefehl = 32'h0;
    logic [31:0] expLesedaten = 32'h0;
    int          befehlPulse = 0;
    int          ladePulse = 0;
    int          speicherPulse = 0;
    int          fehlerPulse = 0;
    int          zyklusGespeichert = -1;

    speicher_antwort #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH_LOG2(10),
        .WAITSTATES(WS)
    ) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .LoadBefehlSignal(LoadBefehlSignal),
        .LoadDatenSignal (LoadDatenSignal),
        .StoreDatenSignal(StoreDatenSignal),
        .Befehlsadresse  (Befehlsadresse),
        .Datenadresse    (Datenadresse),
        .Schreibdaten    (Schreibdaten),
        .Befehl          (Befehl),
        .Lesedaten       (Lesedaten),
        .BefehlGeladen   (BefehlGeladen),
        .DatenGeladen    (DatenGeladen),
        .DatenGespeichert(DatenGespeichert),
        .Fehler          (Fehler)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) zyklus <= zyklus + 1;

    task automatic checkOutput(input string name, input logic [31:0] ist, input logic [31:0] soll);
        checks++;
        if (ist !== soll) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, zyklus, ist, soll);
        end
    endtask

    // Model: each accepted request produces its pulse on a known cycle; outputs hold otherwise
    always @(negedge Clock) begin
        logic      expB, expD, expS, expF, fehl;
        int        idx;
        ErwartungT e;
        if (BefehlGeladen)    befehlPulse++;
        if (DatenGeladen)     ladePulse++;
        if (DatenGespeichert) begin speicherPulse++; zyklusGespeichert = zyklus; end
        if (Fehler)           fehlerPulse++;
        if (modelAktiv) begin
            expB = 1'b0; expD = 1'b0; expS = 1'b0; expF = 1'b0;
            if (erwartet.size() > 0 && erwartet[0].zyklus == zyklus) begin
                e    = erwartet.pop_front();
                fehl = ALIGN && (e.adr % 4 != 0);
                idx  = int'((e.adr / 4) % RAM_WORTE);
                expF = fehl;
                if (e.art == ART_SPEICHERN) begin
                    expS = 1'b1;
                    if (!fehl) ramModel[idx] = e.wert;
                end else if (e.art == ART_LADEN) begin
                    expD = 1'b1;
                    if (!fehl) expLesedaten = ramModel[idx];
                end else begin
                    expB = 1'b1;
                    if (!fehl) expBefehl = ramModel[idx];
                end
            end
            checkOutput("BefehlGeladen", 32'(BefehlGeladen), 32'(expB));
            checkOutput("DatenGeladen", 32'(DatenGeladen), 32'(expD));
            checkOutput("DatenGespeichert", 32'(DatenGespeichert), 32'(expS));
            checkOutput("Fehler", 32'(Fehler), 32'(expF));
            checkOutput("Befehl", Befehl, expBefehl);
            checkOutput("Lesedaten", Lesedaten, expLesedaten);
        end
    end

    task automatic naechsterZyklus();
        @(posedge Clock);
        #2;
    endtask

    task automatic warteBis(input int z);
        while (zyklus < z) naechsterZyklus();
    endtask

    task automatic setzeSignal(input int art, input logic wert);
        if (art == ART_SPEICHERN)   StoreDatenSignal = wert;
        else if (art == ART_LADEN)  LoadDatenSignal  = wert;
        else                        LoadBefehlSignal = wert;
    endtask

    // modus 0: hold inputs, 1: scramble inputs after acceptance, 2: drop request after acceptance
    task automatic applyStimulus(input int art, input logic [31:0] adr, input logic [31:0] wert, input int modus);
        int        k;
        ErwartungT e;
        k = zyklus;
        if (art == ART_BEFEHL) Befehlsadresse = adr;
        else                   Datenadresse   = adr;
        Schreibdaten = wert;
        setzeSignal(art, 1'b1);
        e.zyklus = k + 3 + WS; e.art = art; e.adr = adr; e.wert = wert;
        erwartet.push_back(e);
        naechsterZyklus();
        if (modus == 1) begin
            Befehlsadresse = ~adr;
            Datenadresse   = ~adr;
            Schreibdaten   = ~wert;
        end else if (modus == 2) begin
            setzeSignal(art, 1'b0);
        end
        warteBis(k + 3 + WS);
        setzeSignal(art, 1'b0);
        naechsterZyklus();
    endtask

    task automatic applyReset();
        modelAktiv = 1'b0;
        erwartet.delete();
        Reset = 1'b1;
        naechsterZyklus();
        naechsterZyklus();
        Reset = 1'b0;
        expBefehl    = 32'h0;
        expLesedaten = 32'h0;
        modelAktiv   = 1'b1;
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          start, vorher, k;
        ErwartungT   e;
        logic [31:0] muster [0:2];
        muster[0] = 32'h11111111;
        muster[1] = 32'hA5A55A5A;
        muster[2] = 32'h0000FFFF;

        Reset = 1'b1;
        LoadBefehlSignal = 1'b0; LoadDatenSignal = 1'b0; StoreDatenSignal = 1'b0;
        Befehlsadresse = 32'h0; Datenadresse = 32'h0; Schreibdaten = 32'h0;
        repeat (3) naechsterZyklus();
        Reset = 1'b0;
        modelAktiv = 1'b1;
        checkOutput("reset Befehl", Befehl, 32'h0);
        checkOutput("reset Lesedaten", Lesedaten, 32'h0);
        checkOutput("reset pulses", {29'h0, BefehlGeladen, DatenGeladen, DatenGespeichert}, 32'h0);
        checkOutput("reset Fehler", 32'(Fehler), 32'h0);

        // Store with held address: pulse exactly 4 cycles after the request edge
        start = zyklus;
        applyStimulus(ART_SPEICHERN, 32'h10, 32'hDEADBEEF, 0);
        checkOutput("store latency", 32'(zyklusGespeichert), 32'(start + 1 + 4));

        // Load back, scrambled inputs after acceptance
        applyStimulus(ART_LADEN, 32'h10, 32'h0, 1);
        checkOutput("load DEADBEEF", Lesedaten, 32'hDEADBEEF);
        repeat (3) naechsterZyklus();
        checkOutput("load held", Lesedaten, 32'hDEADBEEF);

        for (int i = 0; i < 3; i++) applyStimulus(ART_SPEICHERN, 32'h40 + 32'(4 * i), muster[i], 1);
        for (int i = 0; i < 3; i++) applyStimulus(ART_LADEN, 32'h40 + 32'(4 * i), 32'h0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(ART_BEFEHL, 32'h40 + 32'(4 * i), 32'h0, 2);
        checkOutput("fetch pattern", Befehl, 32'h0000FFFF);
        checkOutput("load pattern", Lesedaten, 32'h0000FFFF);

        // Store and fetch together: store first, fetch after FREIGABE and back in IDLE
        k = zyklus;
        StoreDatenSignal = 1'b1; Datenadresse = 32'h30; Schreibdaten = 32'h13579BDF;
        LoadBefehlSignal = 1'b1; Befehlsadresse = 32'h30;
        e.zyklus = k + 5;  e.art = ART_SPEICHERN; e.adr = 32'h30; e.wert = 32'h13579BDF;
        erwartet.push_back(e);
        e.zyklus = k + 11; e.art = ART_BEFEHL;    e.adr = 32'h30; e.wert = 32'h0;
        erwartet.push_back(e);
        warteBis(k + 5);
        StoreDatenSignal = 1'b0;
        warteBis(k + 11);
        LoadBefehlSignal = 1'b0;
        naechsterZyklus();
        checkOutput("priority fetch", Befehl, 32'h13579BDF);

        // Held fetch request yields a single pulse
        vorher = befehlPulse;
        k = zyklus;
        LoadBefehlSignal = 1'b1; Befehlsadresse = 32'h10;
        e.zyklus = k + 5; e.art = ART_BEFEHL; e.adr = 32'h10; e.wert = 32'h0;
        erwartet.push_back(e);
        warteBis(k + 20);
        LoadBefehlSignal = 1'b0;
        naechsterZyklus();
        naechsterZyklus();
        checkOutput("held fetch pulses", 32'(befehlPulse - vorher), 32'd1);
        checkOutput("held fetch data", Befehl, 32'hDEADBEEF);

        // Reset during WARTEN cancels the store
        applyStimulus(ART_SPEICHERN, 32'h20, 32'hCAFEF00D, 0);
        vorher = speicherPulse;
        StoreDatenSignal = 1'b1; Datenadresse = 32'h20; Schreibdaten = 32'h12345678;
        naechsterZyklus();
        naechsterZyklus();
        StoreDatenSignal = 1'b0;
        applyReset();
        checkOutput("after reset Lesedaten", Lesedaten, 32'h0);
        repeat (4) naechsterZyklus();
        checkOutput("cancelled store pulses", 32'(speicherPulse - vorher), 32'd0);
        applyStimulus(ART_LADEN, 32'h20, 32'h0, 0);
        checkOutput("old word kept", Lesedaten, 32'hCAFEF00D);

        // Address wrap modulo RAM size
        applyStimulus(ART_LADEN, 32'h1010, 32'h0, 1);
        checkOutput("wrap load", Lesedaten, 32'hDEADBEEF);

        // Misaligned load
        applyStimulus(ART_LADEN, 32'h20, 32'h0, 0);
        vorher = fehlerPulse;
        applyStimulus(ART_LADEN, 32'h12, 32'h0, 0);
`ifdef ALIGN_CHECK_EN
        checkOutput("misaligned unchanged", Lesedaten, 32'hCAFEF00D);
        checkOutput("misaligned Fehler", 32'(fehlerPulse - vorher), 32'd1);
`else
        checkOutput("misaligned word", Lesedaten, 32'hDEADBEEF);
        checkOutput("misaligned Fehler", 32'(fehlerPulse - vorher), 32'd0);
`endif

        repeat (3) naechsterZyklus();
        checkOutput("pending expectations", 32'(erwartet.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
